// File: rtl/sdram_axi_pmem_master.sv
// Bridges the pmem-style request/ack interface onto single-outstanding AXI4 INCR bursts.
// Writes give one ack after the B response; reads give one ack per returned beat.
module sdram_axi_pmem_master #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  inport_wr_i,
    input  logic        inport_rd_i,
    input  logic [7:0]  inport_len_i,
    input  logic [31:0] inport_addr_i,
    input  logic [31:0] inport_write_data_i,
    output logic        inport_accept_o,
    output logic        inport_ack_o,
    output logic        inport_error_o,
    output logic [31:0] inport_read_data_o,
    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic [3:0]  outport_awid_o,
    output logic [7:0]  outport_awlen_o,
    output logic [1:0]  outport_awburst_o,
    input  logic        outport_awready_i,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_wlast_o,
    input  logic        outport_wready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic [3:0]  outport_bid_i,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    input  logic        outport_arready_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i,
    output logic        outport_rready_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WRESP = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_awvalid;
    logic [31:0] r_awaddr;
    logic [7:0]  r_awlen;
    logic        r_wvalid;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_wlast;
    logic [7:0]  r_remaining;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_bready;
    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic        r_rready;
    logic [7:0]  r_expected;
    logic [7:0]  r_beat;
    logic        r_ack;
    logic        r_error;
    logic [31:0] r_rdata;

    logic        w_wr_req;
    logic        w_accept;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_wlast_hs;
    logic        w_b_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_unused;

    assign w_wr_req   = |inport_wr_i;
    assign w_aw_hs    = r_awvalid & outport_awready_i;
    assign w_w_hs     = r_wvalid & outport_wready_i;
    assign w_wlast_hs = w_w_hs & r_wlast;
    assign w_b_hs     = r_bready & outport_bvalid_i;
    assign w_ar_hs    = r_arvalid & outport_arready_i;
    assign w_r_hs     = r_rready & outport_rvalid_i;
    // Completion counts a handshake landing this very cycle so AW and last-W may finish together.
    assign w_aw_done  = r_aw_done | w_aw_hs;
    assign w_w_done   = r_w_done | w_wlast_hs;
    assign w_unused   = ^{inport_addr_i[1:0], outport_bresp_i[0], outport_rresp_i[0]};

    // Next-state selection and combinational request/beat acceptance
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_req) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_WRITE;
                end else if (inport_rd_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_READ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_accept = w_wr_req & (r_remaining != 8'd0) & (~r_wvalid | outport_wready_i);
                if (w_aw_done && w_w_done) begin
                    w_state_next = ST_WRESP;
                end else begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRESP: begin
                if (w_b_hs) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WRESP;
                end
            end
            ST_READ: begin
                if (w_r_hs && outport_rlast_i) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_READ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // AXI channel registers, beat bookkeeping and response generation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_awvalid   <= 1'b0;
            r_awaddr    <= 32'd0;
            r_awlen     <= 8'd0;
            r_wvalid    <= 1'b0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_wlast     <= 1'b0;
            r_remaining <= 8'd0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= 32'd0;
            r_arlen     <= 8'd0;
            r_rready    <= 1'b0;
            r_expected  <= 8'd0;
            r_beat      <= 8'd0;
            r_ack       <= 1'b0;
            r_error     <= 1'b0;
            r_rdata     <= 32'd0;
        end else begin
            r_ack   <= 1'b0;
            r_error <= 1'b0;
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_wr_req) begin
                        r_awvalid   <= 1'b1;
                        r_awaddr    <= {inport_addr_i[31:2], 2'b00};
                        r_awlen     <= inport_len_i;
                        r_wvalid    <= 1'b1;
                        r_wdata     <= inport_write_data_i;
                        r_wstrb     <= inport_wr_i;
                        r_wlast     <= (inport_len_i == 8'd0);
                        r_remaining <= inport_len_i;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                    end else if (w_accept) begin
                        r_arvalid   <= 1'b1;
                        r_araddr    <= {inport_addr_i[31:2], 2'b00};
                        r_arlen     <= inport_len_i;
                        r_expected  <= inport_len_i;
                        r_beat      <= 8'd0;
                        r_rready    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_wlast_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_accept) begin
                        r_wvalid    <= 1'b1;
                        r_wdata     <= inport_write_data_i;
                        r_wstrb     <= inport_wr_i;
                        r_wlast     <= (r_remaining == 8'd1);
                        r_remaining <= r_remaining - 8'd1;
                    end else if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                    end
                end
                ST_WRESP: begin
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_ack    <= 1'b1;
                        r_error  <= outport_bresp_i[1] | (outport_bid_i != AXI_ID);
                    end
                end
                ST_READ: begin
                    if (w_r_hs) begin
                        r_rdata <= outport_rdata_i;
                        r_ack   <= 1'b1;
                        // A beat is also in error when rlast disagrees with the requested length.
                        r_error <= outport_rresp_i[1] | (outport_rid_i != AXI_ID) |
                                   (outport_rlast_i != (r_beat == r_expected));
                        if (r_beat != 8'hFF) begin
                            r_beat <= r_beat + 8'd1;
                        end
                        if (outport_rlast_i) begin
                            r_rready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_ack <= 1'b0;
                end
            endcase
        end
    end

    assign inport_accept_o    = w_accept;
    assign inport_ack_o       = r_ack;
    assign inport_error_o     = r_error;
    assign inport_read_data_o = r_rdata;
    assign outport_awvalid_o  = r_awvalid;
    assign outport_awaddr_o   = r_awaddr;
    assign outport_awid_o     = AXI_ID;
    assign outport_awlen_o    = r_awlen;
    assign outport_awburst_o  = 2'b01;
    assign outport_wvalid_o   = r_wvalid;
    assign outport_wdata_o    = r_wdata;
    assign outport_wstrb_o    = r_wstrb;
    assign outport_wlast_o    = r_wlast;
    assign outport_bready_o   = r_bready;
    assign outport_arvalid_o  = r_arvalid;
    assign outport_araddr_o   = r_araddr;
    assign outport_arid_o     = AXI_ID;
    assign outport_arlen_o    = r_arlen;
    assign outport_arburst_o  = 2'b01;
    assign outport_rready_o   = r_rready;

endmodule

// File: tb/tb_sdram_axi_pmem_master.sv
// Directed bench for sdram_axi_pmem_master: a transaction-level model with queues is checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_sdram_axi_pmem_master;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  wr = 4'd0;
    logic        rd = 1'b0;
    logic [7:0]  len = 8'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        accept, ack, error;
    logic [31:0] read_data;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  awid, arid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  bresp = 2'd0, rresp = 2'd0;
    logic [3:0]  bid = 4'd0, rid = 4'd0;
    logic [31:0] rdata = 32'd0;

    sdram_axi_pmem_master #(.AXI_ID(4'd0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .inport_wr_i(wr), .inport_rd_i(rd), .inport_len_i(len), .inport_addr_i(addr),
        .inport_write_data_i(wdata_in), .inport_accept_o(accept), .inport_ack_o(ack),
        .inport_error_o(error), .inport_read_data_o(read_data),
        .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr), .outport_awid_o(awid),
        .outport_awlen_o(awlen), .outport_awburst_o(awburst), .outport_awready_i(awready),
        .outport_wvalid_o(wvalid), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
        .outport_wlast_o(wlast), .outport_wready_i(wready),
        .outport_bvalid_i(bvalid), .outport_bresp_i(bresp), .outport_bid_i(bid),
        .outport_bready_o(bready),
        .outport_arvalid_o(arvalid), .outport_araddr_o(araddr), .outport_arid_o(arid),
        .outport_arlen_o(arlen), .outport_arburst_o(arburst), .outport_arready_i(arready),
        .outport_rvalid_i(rvalid), .outport_rdata_i(rdata), .outport_rresp_i(rresp),
        .outport_rid_i(rid), .outport_rlast_i(rlast), .outport_rready_o(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // slave configuration
    int         aw_delay = 0, ar_delay = 0, wmode = 0;
    logic [1:0] cfg_bresp = 2'd0;
    int         r_n = 1, r_last_idx = 0, r_bad_idx = 99;
    logic [31:0] r_base = 32'd0;

    // logs of what the DUT actually did
    int          ack_cnt = 0;
    logic [31:0] ack_data_log[$];
    logic        ack_err_log[$];
    logic        ack_rd_log[$];
    logic [31:0] aw_log[$];
    logic [31:0] ar_log[$];
    logic [31:0] w_data_log[$];
    logic        w_last_log[$];

    // transaction-level model
    localparam int P_IDLE = 0, P_WR = 1, P_WRESP = 2, P_RD = 3;
    typedef struct packed { logic [31:0] d; logic [3:0] s; logic l; } wbeat_t;
    wbeat_t      wq[$];
    int          m_phase = P_IDLE;
    logic        m_aw_pend = 1'b0, m_ar_pend = 1'b0, m_aw_done = 1'b0, m_w_done = 1'b0;
    logic [31:0] m_aw_addr = 32'd0, m_ar_addr = 32'd0, m_rdata = 32'd0;
    logic [7:0]  m_aw_len = 8'd0, m_ar_len = 8'd0;
    int          m_rem = 0, m_rd_idx = 0, m_rd_len = 0;
    logic        m_ack_due = 1'b0, m_ack_rd = 1'b0, m_err = 1'b0, m_after_rst = 1'b0;

    always @(negedge clk) begin : mon
        int     ph0;
        logic   exp_acc;
        wbeat_t hd;
        if (rst_i) begin
            m_phase = P_IDLE; m_aw_pend = 1'b0; m_ar_pend = 1'b0;
            m_aw_done = 1'b0; m_w_done = 1'b0; m_ack_due = 1'b0;
            wq.delete();
            m_after_rst = 1'b1;
        end else begin
            if (m_after_rst) begin
                chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, ack, error}, 64'd0);
                chk("rst_addr", {awaddr, araddr}, 64'd0);
                chk("rst_data", {wdata, read_data}, 64'd0);
                chk("rst_len", {awlen, arlen, wstrb, wlast}, 64'd0);
                m_after_rst = 1'b0;
            end
            chk("ack", ack, m_ack_due);
            if (m_ack_due) begin
                chk("ack_error", error, m_err);
                if (m_ack_rd) chk("read_data", read_data, m_rdata);
            end
            if (ack) begin
                ack_cnt++;
                ack_data_log.push_back(read_data);
                ack_err_log.push_back(error);
                ack_rd_log.push_back(m_ack_rd);
            end
            m_ack_due = 1'b0;
            ph0 = m_phase;
            chk("awvalid", awvalid, m_aw_pend);
            chk("arvalid", arvalid, m_ar_pend);
            chk("wvalid", wvalid, wq.size() != 0);
            chk("bready", bready, ph0 == P_WRESP);
            chk("rready", rready, ph0 == P_RD);
            if (ph0 == P_IDLE) exp_acc = (wr != 4'd0) || rd;
            else if (ph0 == P_WR) exp_acc = (wr != 4'd0) && (m_rem != 0) && (wq.size() == 0 || wready);
            else exp_acc = 1'b0;
            chk("accept", accept, exp_acc);
            if (awvalid && m_aw_pend)
                chk("aw_payload", {awaddr, awlen, awburst, awid}, {m_aw_addr, m_aw_len, 2'b01, 4'h0});
            if (arvalid && m_ar_pend)
                chk("ar_payload", {araddr, arlen, arburst, arid}, {m_ar_addr, m_ar_len, 2'b01, 4'h0});
            if (wvalid && wq.size() != 0)
                chk("w_payload", {wdata, wstrb, wlast}, wq[0]);
            // handshakes observed now take effect at the coming rising edge
            if (awvalid && awready) begin
                m_aw_pend = 1'b0; m_aw_done = 1'b1; aw_log.push_back(awaddr);
            end
            if (wvalid && wready && wq.size() != 0) begin
                hd = wq.pop_front();
                if (hd.l) m_w_done = 1'b1;
                w_data_log.push_back(wdata); w_last_log.push_back(wlast);
            end
            if (ph0 == P_WR && m_aw_done && m_w_done) m_phase = P_WRESP;
            if (ph0 == P_WRESP && bvalid && bready) begin
                m_ack_due = 1'b1; m_ack_rd = 1'b0;
                m_err = bresp[1] | (bid != 4'd0);
                m_phase = P_IDLE;
            end
            if (arvalid && arready) begin
                m_ar_pend = 1'b0; ar_log.push_back(araddr);
            end
            if (ph0 == P_RD && rvalid && rready) begin
                m_ack_due = 1'b1; m_ack_rd = 1'b1; m_rdata = rdata;
                m_err = rresp[1] | (rid != 4'd0) | (rlast != (m_rd_idx == m_rd_len));
                m_rd_idx++;
                if (rlast) m_phase = P_IDLE;
            end
            if (exp_acc && ph0 == P_IDLE && wr != 4'd0) begin
                m_phase = P_WR; m_aw_pend = 1'b1; m_aw_addr = {addr[31:2], 2'b00};
                m_aw_len = len; m_rem = int'(len); m_aw_done = 1'b0; m_w_done = 1'b0;
                wq.push_back('{d: wdata_in, s: wr, l: (len == 8'd0)});
            end else if (exp_acc && ph0 == P_IDLE) begin
                m_phase = P_RD; m_ar_pend = 1'b1; m_ar_addr = {addr[31:2], 2'b00};
                m_ar_len = len; m_rd_idx = 0; m_rd_len = int'(len);
            end else if (exp_acc && ph0 == P_WR) begin
                wq.push_back('{d: wdata_in, s: wr, l: (m_rem == 1)});
                m_rem--;
            end
        end
    end

    // AW / AR slaves: ready after a configurable delay
    initial begin : aw_slave
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin
                if (cnt >= aw_delay) awready = 1'b1;
                cnt++;
            end else begin
                awready = 1'b0; cnt = 0;
            end
        end
    end

    initial begin : ar_slave
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (arvalid) begin
                if (cnt >= ar_delay) arready = 1'b1;
                cnt++;
            end else begin
                arready = 1'b0; cnt = 0;
            end
        end
    end

    initial begin : w_slave
        forever begin
            @(posedge clk); #1;
            wready = (wmode != 0) ? ~wready : 1'b1;
        end
    end

    initial begin : b_slave
        logic hs;
        forever begin
            @(negedge clk); hs = bvalid & bready;
            @(posedge clk); #1;
            if (hs) bvalid = 1'b0;
            else if (bready && !bvalid) begin
                bvalid = 1'b1; bresp = cfg_bresp; bid = 4'd0;
            end
        end
    end

    initial begin : r_slave
        logic last_now;
        forever begin
            @(negedge clk);
            if (arvalid && arready) begin
                @(posedge clk); #1;
                for (int i = 0; i < r_n; i++) begin
                    if (i % 3 == 1) begin
                        rvalid = 1'b0; @(posedge clk); #1;
                    end
                    last_now = (i == r_last_idx);
                    rvalid = 1'b1; rdata = r_base + i; rlast = last_now;
                    rid = (i == r_bad_idx) ? 4'h5 : 4'h0; rresp = 2'b00;
                    for (int t = 0; t < 200; t++) begin
                        @(negedge clk);
                        if (rready) break;
                    end
                    @(posedge clk); #1;
                    if (last_now) break;
                end
                rvalid = 1'b0; rlast = 1'b0; rid = 4'h0;
            end
        end
    end

    task automatic clear_logs();
        ack_cnt = 0;
        ack_data_log.delete(); ack_err_log.delete(); ack_rd_log.delete();
        aw_log.delete(); ar_log.delete(); w_data_log.delete(); w_last_log.delete();
    endtask

    task automatic idle_inputs();
        wr = 4'd0; rd = 1'b0;
    endtask

    task automatic wait_accept(input string name);
        int t;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (accept) break;
            @(posedge clk); #1;
        end
        if (t == 300) begin
            checks++; failures++;
            $display("FAIL %s_accept_timeout actual=none required=accept", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(input string name, input logic [3:0] w, input logic r,
                         input logic [31:0] a, input logic [7:0] l, input logic [31:0] d);
        wr = w; rd = r; addr = a; len = l; wdata_in = d;
        wait_accept(name);
    endtask

    task automatic wait_acks(input string name, input int n);
        for (int t = 0; t < 300 && ack_cnt < n; t++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_ack_count"}, ack_cnt, n);
    endtask

    initial begin : main
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk); #1;

        // single write, awready late
        clear_logs(); aw_delay = 3; wmode = 0; cfg_bresp = 2'b00;
        issue("t1", 4'hF, 1'b0, 32'h0000_1003, 8'd0, 32'hDEAD_BEEF);
        idle_inputs();
        wait_acks("t1", 1);
        chk("t1_aw_n", aw_log.size(), 1);
        if (aw_log.size() == 1) chk("t1_awaddr", aw_log[0], 32'h0000_1000);
        chk("t1_w_n", w_data_log.size(), 1);
        if (w_data_log.size() == 1) chk("t1_wbeat", {w_data_log[0], w_last_log[0]}, {32'hDEAD_BEEF, 1'b1});
        if (ack_cnt == 1) chk("t1_err", ack_err_log[0], 1'b0);

        // write burst with wready toggling
        clear_logs(); aw_delay = 0; wmode = 1;
        for (int i = 1; i <= 4; i++) issue("t2", 4'hF, 1'b0, 32'h0000_2000, 8'd3, i);
        idle_inputs();
        wait_acks("t2", 1);
        chk("t2_w_n", w_data_log.size(), 4);
        for (int i = 0; i < 4 && i < w_data_log.size(); i++)
            chk("t2_wbeat", {w_data_log[i], w_last_log[i]}, {i + 1, i == 3});
        wmode = 0;

        // read burst with rvalid gaps
        clear_logs(); ar_delay = 1; r_n = 8; r_last_idx = 7; r_bad_idx = 99; r_base = 32'hA0;
        issue("t3", 4'h0, 1'b1, 32'h0000_0100, 8'd7, 32'd0);
        idle_inputs();
        wait_acks("t3", 8);
        if (ar_log.size() == 1) chk("t3_araddr", ar_log[0], 32'h0000_0100);
        for (int i = 0; i < 8 && i < ack_cnt; i++)
            chk("t3_ack", {ack_data_log[i], ack_err_log[i]}, {32'hA0 + i, 1'b0});
        chk("t3_rready_low", rready, 1'b0);

        // write with SLVERR response
        clear_logs(); cfg_bresp = 2'b10;
        issue("t4", 4'h3, 1'b0, 32'h0000_3000, 8'd0, 32'h1234_5678);
        idle_inputs();
        wait_acks("t4", 1);
        if (ack_cnt == 1) chk("t4_err", ack_err_log[0], 1'b1);
        cfg_bresp = 2'b00;

        // read len 3, slave ends early with rlast on beat 2
        clear_logs(); r_n = 4; r_last_idx = 2; r_base = 32'hB0;
        issue("t5", 4'h0, 1'b1, 32'h0000_0200, 8'd3, 32'd0);
        idle_inputs();
        wait_acks("t5", 3);
        if (ack_cnt == 3) chk("t5_errs", {ack_err_log[0], ack_err_log[1], ack_err_log[2]}, 3'b001);
        chk("t5_rready_low", rready, 1'b0);

        // read with a wrong rid on beat 0
        clear_logs(); r_n = 2; r_last_idx = 1; r_bad_idx = 0; r_base = 32'hC0;
        issue("t6", 4'h0, 1'b1, 32'h0000_0300, 8'd1, 32'd0);
        idle_inputs();
        wait_acks("t6", 2);
        if (ack_cnt == 2) chk("t6_errs", {ack_err_log[0], ack_err_log[1]}, 2'b10);
        r_bad_idx = 99;

        // simultaneous write and read: write first, read after the write ack
        clear_logs(); r_n = 1; r_last_idx = 0; r_base = 32'h77;
        issue("t7w", 4'hF, 1'b1, 32'h0000_0300, 8'd0, 32'h55);
        wr = 4'h0; addr = 32'h0000_0400;
        wait_accept("t7r");
        idle_inputs();
        wait_acks("t7", 2);
        if (ack_cnt == 2) chk("t7_order", {ack_rd_log[0], ack_rd_log[1], ack_data_log[1]}, {2'b01, 32'h77});
        if (aw_log.size() == 1 && ar_log.size() == 1)
            chk("t7_addrs", {aw_log[0], ar_log[0]}, {32'h0000_0300, 32'h0000_0400});

        // reset in the middle of a write burst
        clear_logs(); aw_delay = 50;
        issue("t8", 4'hF, 1'b0, 32'h0000_0500, 8'd3, 32'd11);
        issue("t8", 4'hF, 1'b0, 32'h0000_0500, 8'd3, 32'd12);
        idle_inputs();
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        aw_delay = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("t8_w_n", w_data_log.size(), 2);
        chk("t8_no_ack", ack_cnt, 0);
        clear_logs(); r_base = 32'h99;
        issue("t8r", 4'h0, 1'b1, 32'h0000_0600, 8'd0, 32'd0);
        idle_inputs();
        wait_acks("t8r", 1);
        if (ack_cnt == 1) chk("t8_read", {ack_data_log[0], ack_err_log[0]}, {32'h99, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
